// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } debounce_state_t;

  localparam int DEFAULT_STABLE_SAMPLES = 20;
  localparam int DEFAULT_SYNC_STAGES    = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous (or foreign-phase) bit.
module bit_synchronizer
  import debounce_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic masterClock,
  input  logic masterResetN,
  input  logic asyncIn,
  output logic syncOut
);

  logic [STAGES-1:0] stage_reg;

  always_ff @(posedge masterClock or negedge masterResetN) begin
    if (!masterResetN) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], asyncIn};
    end
  end

  assign syncOut = stage_reg[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one push-button: samples the synchronized pin on each rise of the
// divided sample clock and only changes level after a run of agreeing samples.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
  input  logic masterClock,
  input  logic masterResetN,
  input  logic sampleClock,
  input  logic rawButton,
  output logic debouncedButton,
  output logic pressPulse,
  output logic releasePulse
);

  localparam int             CW         = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0]  ONE        = CW'(1);
  localparam logic [CW-1:0]  LAST_COUNT = CW'(STABLE_SAMPLES);
  localparam bit             SINGLE     = (STABLE_SAMPLES == 1);

  logic            sync_button;
  logic            sample_sync;
  logic            sample_prev;
  logic            sample_enable;
  debounce_state_t state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_inc;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) button_sync (
    .masterClock  (masterClock),
    .masterResetN (masterResetN),
    .asyncIn      (rawButton),
    .syncOut      (sync_button)
  );

  bit_synchronizer #(.STAGES(2)) sample_clock_sync (
    .masterClock  (masterClock),
    .masterResetN (masterResetN),
    .asyncIn      (sampleClock),
    .syncOut      (sample_sync)
  );

  assign sample_enable = sample_sync & ~sample_prev;
  assign count_inc     = count + ONE;

  // Pulses default low every cycle so each lasts exactly one cycle.
  always_ff @(posedge masterClock or negedge masterResetN) begin
    if (!masterResetN) begin
      sample_prev     <= 1'b0;
      state           <= RELEASED;
      count           <= '0;
      debouncedButton <= 1'b0;
      pressPulse      <= 1'b0;
      releasePulse    <= 1'b0;
    end else begin
      sample_prev  <= sample_sync;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      if (sample_enable) begin
        case (state)
          RELEASED: begin
            if (sync_button) begin
              if (SINGLE) begin
                state           <= HELD;
                debouncedButton <= 1'b1;
                pressPulse      <= 1'b1;
                count           <= '0;
              end else begin
                state <= CONFIRM_PRESS;
                count <= ONE;
              end
            end
          end
          CONFIRM_PRESS: begin
            if (sync_button) begin
              if (count_inc == LAST_COUNT) begin
                state           <= HELD;
                debouncedButton <= 1'b1;
                pressPulse      <= 1'b1;
                count           <= '0;
              end else begin
                count <= count_inc;
              end
            end else begin
              state <= RELEASED;
              count <= '0;
            end
          end
          HELD: begin
            if (!sync_button) begin
              if (SINGLE) begin
                state           <= RELEASED;
                debouncedButton <= 1'b0;
                releasePulse    <= 1'b1;
                count           <= '0;
              end else begin
                state <= CONFIRM_RELEASE;
                count <= ONE;
              end
            end
          end
          CONFIRM_RELEASE: begin
            if (!sync_button) begin
              if (count_inc == LAST_COUNT) begin
                state           <= RELEASED;
                debouncedButton <= 1'b0;
                releasePulse    <= 1'b1;
                count           <= '0;
              end else begin
                count <= count_inc;
              end
            end else begin
              state <= HELD;
              count <= '0;
            end
          end
          default: begin
            state <= RELEASED;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with STABLE_SAMPLES=4, one sample enable per 4 cycles.
module tb_button_debouncer;

  typedef struct packed {
    logic raw;
    logic db;
    logic press;
    logic rel;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sample_clock;
  logic raw_button;
  logic debounced;
  logic press_pulse;
  logic release_pulse;

  int   total = 0;
  int   passed = 0;
  int   press_seen = 0;
  int   release_seen = 0;
  int   both_seen = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  button_debouncer #(.STABLE_SAMPLES(4), .SYNC_STAGES(2)) dut (
    .masterClock     (clk),
    .masterResetN    (rst_n),
    .sampleClock     (sample_clock),
    .rawButton       (raw_button),
    .debouncedButton (debounced),
    .pressPulse      (press_pulse),
    .releasePulse    (release_pulse)
  );

  always @(negedge clk) begin
    if (press_pulse) press_seen++;
    if (release_pulse) release_seen++;
    if (press_pulse && release_pulse) both_seen++;
  end

  function automatic vec_t mk(input logic r, input logic d, input logic p, input logic l);
    vec_t v;
    v.raw = r; v.db = d; v.press = p; v.rel = l;
    return v;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b required %b", name, act, exp);
    else passed++;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d required %0d", name, act, exp);
    else passed++;
  endtask

  // One full sample period: rise before edge k, FSM decides at edge k+2.
  task automatic sample_step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    raw_button   = v.raw;
    sample_clock = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sample_clock = 1'b0;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_int($sformatf("s%0d_queue", idx), 0, 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("s%0d_db", idx), debounced, e.db);
      check($sformatf("s%0d_press", idx), press_pulse, e.press);
      check($sformatf("s%0d_release", idx), release_pulse, e.rel);
    end
    $display("sample %0d raw=%b db=%b press=%b release=%b", idx, v.raw, debounced,
             press_pulse, release_pulse);
    @(posedge clk);
    #1;
    check($sformatf("s%0d_press_width", idx), press_pulse, 1'b0);
    check($sformatf("s%0d_release_width", idx), release_pulse, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with button held, then release: press after 4th sample
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0));
    // clean release
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0));
    // clean press, then held
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0));
    // release with bounce: 0,0,1 then 0 x4
    vecs.push_back(mk(0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1));
    // press bounce: 1 x3, 0, then 1 x4
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0));
    // enter CONFIRM_RELEASE ahead of mid-operation reset
    vecs.push_back(mk(0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0));

    rst_n        = 1'b0;
    raw_button   = 1'b1;
    sample_clock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_db", debounced, 1'b0);
    check("reset_press", press_pulse, 1'b0);
    check("reset_release", release_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) sample_step(vecs[i], i + 1);

    // asynchronous reset mid-cycle while in CONFIRM_RELEASE
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_db", debounced, 1'b0);
    check("midreset_press", press_pulse, 1'b0);
    check("midreset_release", release_pulse, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) sample_step(mk(0, 0, 0, 0), 100 + i);
    for (int i = 0; i < 2; i++) sample_step(mk(1, 0, 0, 0), 110 + i);

    // third press sample comes from a rise that then stays high
    @(negedge clk);
    raw_button   = 1'b1;
    sample_clock = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("frozen_enter_db", debounced, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      raw_button = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check($sformatf("frozen%0d_db", i), debounced, 1'b0);
      check($sformatf("frozen%0d_press", i), press_pulse, 1'b0);
    end
    $display("frozen window done db=%b", debounced);
    @(negedge clk);
    raw_button   = 1'b1;
    sample_clock = 1'b0;
    repeat (3) @(negedge clk);
    sample_step(mk(1, 1, 1, 0), 120);

    repeat (4) @(posedge clk);
    check_int("press_total", press_seen, 4);
    check_int("release_total", release_seen, 2);
    check_int("pulse_overlap", both_seen, 0);
    check_int("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces one mechanical push-button input on the Zybo board. It sits directly downstream of the clock divider: the divider's slow `dividedClock` output enters here as a level (`sampleClock`), and the block turns each of its rising edges into a one-cycle sample enable in the `masterClock` domain. It drives a clean `debouncedButton` level plus one-cycle press and release pulses for the control logic.

## Interface
- Parameters
  - `STABLE_SAMPLES`, default 20: consecutive agreeing samples required to change the output. Must be ≥ 1.
  - `SYNC_STAGES`, default 2: flop depth of the `rawButton` synchronizer. Must be ≥ 2.
- Ports
  - `masterClock` in 1: single system clock, 125 MHz board clock.
  - `masterResetN` in 1: asynchronous, active-low reset.
  - `sampleClock` in 1: divided-clock level from the divider, produced synchronously to `masterClock`.
  - `rawButton` in 1: asynchronous pin, active-high.
  - `debouncedButton` out 1: filtered button level.
  - `pressPulse` out 1: high for exactly one `masterClock` cycle on each confirmed press.
  - `releasePulse` out 1: high for exactly one `masterClock` cycle on each confirmed release.

## Operation
- **Reset.** While `masterResetN`=0, all of the following are cleared immediately, regardless of clock:
  - state = `RELEASED`
  - counter = 0
  - all synchronizer and history flops = 0
  - `debouncedButton`, `pressPulse`, `releasePulse` = 0
- **Button synchronization.** `rawButton` passes through `SYNC_STAGES` flops to give `syncButton`.
- **Sample enable.** `sampleClock` passes through 2 flops to give `sampleSync`, then 1 history flop `samplePrev`. `sampleEnable` = `sampleSync` & ~`samplePrev`.
- **Counter width.** The counter is `$clog2(STABLE_SAMPLES+1)` bits and never exceeds `STABLE_SAMPLES`.
- **FSM.** The state and counter update only on cycles where `sampleEnable`=1; otherwise everything holds.
  - `RELEASED`:
    - `syncButton`=1 → `CONFIRM_PRESS`, counter=1.
    - If `STABLE_SAMPLES`=1, go directly to `HELD` with the press actions instead.
  - `CONFIRM_PRESS`:
    - `syncButton`=1 → counter+1. When the new count equals `STABLE_SAMPLES`: go to `HELD`, set `debouncedButton`=1, pulse `pressPulse`, clear counter.
    - `syncButton`=0 → `RELEASED`, counter=0, no pulse.
  - `HELD`:
    - `syncButton`=0 → `CONFIRM_RELEASE`, counter=1, with the same `STABLE_SAMPLES`=1 shortcut.
  - `CONFIRM_RELEASE`:
    - `syncButton`=0 → counter+1. When the new count equals `STABLE_SAMPLES`: go to `RELEASED`, set `debouncedButton`=0, pulse `releasePulse`, clear counter.
    - `syncButton`=1 → `HELD`, counter=0, no pulse.
- **Pulses.** Both pulses are registered and high only in the cycle after the deciding edge. `pressPulse` and `releasePulse` are never high together.
- **Input held constant.** If `sampleClock` stays at a fixed level, no sample enables occur and the outputs are frozen, whatever `rawButton` does.

## Timing
- **Sample enable timing.** A `sampleClock` rise present before edge k gives `sampleEnable`=1 in the cycle between edges k+1 and k+2. The FSM samples at edge k+2.
- **Sample enable width.** Exactly one cycle per `sampleClock` rise.
- **`sampleClock` phase length.** Each high and low phase must be ≥ 1 `masterClock` cycle. This holds for any divider setting ≥ 2.
- **Button latency.** A `rawButton` change is visible on `syncButton` after `SYNC_STAGES` edges.
- **Press latency.** `debouncedButton` rises at the edge of the `STABLE_SAMPLES`-th consecutive high sample. `pressPulse` is high for that same following cycle only. Release is symmetric.
- **Reset mid-operation.** Asserting reset in a `CONFIRM_*` state or in `HELD` clears all outputs combinationally-asynchronously. No pulse is emitted.
- **Reset release.** The first sample enable can occur no earlier than the 3rd edge after reset deassertion.

## Structure
- **Shared package `debounce_pkg`:**
  - `typedef enum logic [1:0] {RELEASED, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} debounce_state_t`
  - default constants `DEFAULT_STABLE_SAMPLES`=20 and `DEFAULT_SYNC_STAGES`=2.
- **Sub-module `bit_synchronizer`:** parameter `STAGES`; ports `masterClock`, `masterResetN`, `asyncIn`, `syncOut`. Instantiated twice: for `rawButton` (`SYNC_STAGES`) and for `sampleClock` (2).
- **Top level:** rise detect, counter, FSM and output registers stay in `button_debouncer`.

## Test plan
All scenarios use `STABLE_SAMPLES`=4, `SYNC_STAGES`=2, and `sampleClock` toggling every 2 cycles (one sample enable per 4 cycles).
- **Reset:** hold reset with `rawButton`=1 → all outputs 0. Release reset → `debouncedButton`=1 after the 4th sample enable, with one `pressPulse`.
- **Clean press:** `rawButton` 0→1 and held → `debouncedButton` rises at the 4th sample; `pressPulse` high exactly 1 cycle; `releasePulse` stays 0.
- **Bounce:** 1 for 3 samples, 0 for 1 sample, then 1 for 4 samples → no pulse after the first burst; state returns to `RELEASED`; press confirmed on the 4th sample of the second burst.
- **Release with bounce:** from `HELD`, 0 for 2 samples, 1 for 1 sample, then 0 for 4 samples → `releasePulse` only after the final 4-sample run.
- **Mid-operation reset:** reset asserted in `CONFIRM_RELEASE` while `debouncedButton`=1 → `debouncedButton` drops immediately; no `releasePulse` at any point.
- **Frozen sample clock:** hold `sampleClock`=1 for 100 cycles while toggling `rawButton` → no output changes; the next `sampleClock` rise resumes counting from the previous state.
